// File: rtl/m_ifetch_line.sv
// Instruction fetch line buffer: one demand line filled by ascending word reads on a miss.
// Defining IFETCH_PREFETCH_EN adds a next-line prefetch buffer filled in state PF.
module m_ifetch_line #(
    parameter int          LINE_WORDS = 4,
    parameter logic [31:0] RESET_IR   = 32'h13
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic [31:0] w_pc,
    output logic [31:0] w_ir,
    output logic        w_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int               OFF_W     = $clog2(LINE_WORDS);
    localparam int               TAG_W     = 30 - OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
`ifdef IFETCH_PREFETCH_EN
        PF,
`endif
        DONE
    } state_t;

    state_t           state_q, state_n;
    logic [OFF_W-1:0] beat_q, beat_n;
    logic [TAG_W-1:0] base_q, base_n;
    logic [TAG_W-1:0] tag_q, tag_n;
    logic             valid_q, valid_n;
    logic [31:0]      words [LINE_WORDS];
    logic             d_we;

    logic [TAG_W-1:0] pc_line;
    logic [OFF_W-1:0] pc_off;
    logic             d_hit, pf_hit, ack;
    logic             unused_pc_bits;

    assign pc_line        = w_pc[31:OFF_W+2];
    assign pc_off         = w_pc[OFF_W+1:2];
    assign unused_pc_bits = ^w_pc[1:0];
    assign d_hit          = valid_q && (tag_q == pc_line);
    assign ack            = mem_req && mem_ack;

`ifdef IFETCH_PREFETCH_EN
    logic [TAG_W-1:0] pf_tag_q, pf_tag_n;
    logic             pf_valid_q, pf_valid_n;
    logic [31:0]      pf_words [LINE_WORDS];
    logic             pf_we, copy;

    assign pf_hit  = pf_valid_q && (pf_tag_q == pc_line);
    assign mem_req = (state_q == FILL) || (state_q == PF);
`else
    assign pf_hit  = 1'b0;
    assign mem_req = (state_q == FILL);
`endif

    assign w_stall  = !(d_hit || pf_hit);
    assign mem_addr = mem_req ? {base_q, beat_q, 2'b00} : 32'h0;

    always_comb begin
        w_ir = RESET_IR;
        if (d_hit)
            w_ir = words[pc_off];
`ifdef IFETCH_PREFETCH_EN
        else if (pf_hit)
            w_ir = pf_words[pc_off];
`endif
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_n = state_q;
        beat_n  = beat_q;
        base_n  = base_q;
        tag_n   = tag_q;
        valid_n = valid_q;
        d_we    = 1'b0;
`ifdef IFETCH_PREFETCH_EN
        pf_tag_n   = pf_tag_q;
        pf_valid_n = pf_valid_q;
        pf_we      = 1'b0;
        copy       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (w_stall) begin
                    state_n = FILL;
                    valid_n = 1'b0;
                    base_n  = pc_line;
                    beat_n  = '0;
                end
`ifdef IFETCH_PREFETCH_EN
                else if (pf_hit && !d_hit) begin
                    copy       = 1'b1;
                    tag_n      = pf_tag_q;
                    valid_n    = 1'b1;
                    pf_valid_n = 1'b0;
                end
`endif
            end
            FILL: begin
                if (ack) begin
                    d_we   = 1'b1;
                    beat_n = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        valid_n = 1'b1;
                        tag_n   = base_q;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
`ifdef IFETCH_PREFETCH_EN
                state_n    = PF;
                base_n     = base_q + 1'b1;
                beat_n     = '0;
                pf_valid_n = 1'b0;
`else
                state_n = IDLE;
`endif
            end
`ifdef IFETCH_PREFETCH_EN
            PF: begin
                // A demand miss may only redirect once the outstanding beat is acknowledged.
                if (ack) begin
                    pf_we  = 1'b1;
                    beat_n = beat_q + 1'b1;
                    if (w_stall) begin
                        state_n    = FILL;
                        base_n     = pc_line;
                        beat_n     = '0;
                        valid_n    = 1'b0;
                        pf_valid_n = 1'b0;
                    end else if (beat_q == LAST_BEAT) begin
                        pf_valid_n = 1'b1;
                        pf_tag_n   = base_q;
                        state_n    = IDLE;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
            pf_tag_q   <= '0;
            pf_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            beat_q  <= beat_n;
            base_q  <= base_n;
            tag_q   <= tag_n;
            valid_q <= valid_n;
`ifdef IFETCH_PREFETCH_EN
            pf_tag_q   <= pf_tag_n;
            pf_valid_q <= pf_valid_n;
`endif
        end
    end

    // NOTE: line data is not reset; the valid bits alone guard it, keeping the arrays plain RAM-like storage.
    always_ff @(posedge w_clk) begin
        if (d_we)
            words[beat_q] <= mem_rdata;
`ifdef IFETCH_PREFETCH_EN
        if (copy)
            for (int i = 0; i < LINE_WORDS; i++)
                words[i] <= pf_words[i];
        if (pf_we)
            pf_words[beat_q] <= mem_rdata;
`endif
    end

endmodule

// File: tb/tb_m_ifetch_line.sv
// Directed bench for m_ifetch_line: a small memory responder plus a linear sequence of
// fetches with hand-derived cycle-by-cycle expectations (LINE_WORDS=4, 16-byte lines).
module tb_m_ifetch_line;
    localparam logic [31:0] NOP = 32'h13;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic [31:0] w_pc = 32'h0;
    logic [31:0] w_ir;
    logic        w_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;
    logic        resp_ack = 1'b0;
    logic        stray_ack = 1'b0;

    logic [31:0] delay_addr = 32'hFFFF_FFFF;
    int          delay_n = 0;
    int          wait_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    assign mem_ack = resp_ack | stray_ack;

    m_ifetch_line #(.LINE_WORDS(4), .RESET_IR(NOP)) dut (
        .w_clk     (w_clk),
        .w_rst_n   (w_rst_n),
        .w_pc      (w_pc),
        .w_ir      (w_ir),
        .w_stall   (w_stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 w_clk = ~w_clk;

    // Memory contents: each word holds C0DE in the top half and its own byte address below.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {16'hC0DE, a[15:2], 2'b00};
    endfunction

    // Responder decides at the falling edge; the DUT samples the ack at the next rising edge.
    always @(negedge w_clk) begin
        if (w_rst_n && mem_req) begin
            if (mem_addr == delay_addr && wait_cnt < delay_n) begin
                resp_ack  = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                wait_cnt  = wait_cnt + 1;
            end else begin
                resp_ack  = 1'b1;
                mem_rdata = word_at(mem_addr);
                wait_cnt  = 0;
            end
        end else begin
            resp_ack  = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            wait_cnt  = 0;
        end
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic s, input logic r,
                              input logic [31:0] a, input logic [31:0] ir);
        check_bit({tag, ".stall"}, w_stall, s);
        check_bit({tag, ".req"}, mem_req, r);
        check_word({tag, ".addr"}, mem_addr, a);
        check_word({tag, ".ir"}, w_ir, ir);
    endtask

    task automatic tick();
        @(posedge w_clk);
        #2;
    endtask

    task automatic set_pc(input logic [31:0] a);
        w_pc = a;
        #1;
    endtask

    // Miss at w_pc==base in IDLE with single-cycle acks: 4 beats, then a hit on the next cycle.
    task automatic run_fill(input logic [31:0] base, input string tag);
        expect_out({tag, ".miss"}, 1'b1, 1'b0, 32'h0, NOP);
        for (int b = 0; b < 4; b++) begin
            tick();
            expect_out($sformatf("%s.beat%0d", tag, b), 1'b1, 1'b1, base + 32'(4 * b), NOP);
        end
        tick();
        expect_out({tag, ".done"}, 1'b0, 1'b0, 32'h0, word_at(base));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) tick();
        expect_out("reset", 1'b1, 1'b0, 32'h0, NOP);

        w_rst_n = 1'b1;
        set_pc(32'h0);
        run_fill(32'h0, "fill0");

`ifdef IFETCH_PREFETCH_EN
        for (int b = 0; b < 4; b++) begin
            tick();
            expect_out($sformatf("pf.beat%0d", b), 1'b0, 1'b1, 32'h10 + 32'(4 * b), word_at(32'h0));
        end
        tick();
        set_pc(32'h10);
        expect_out("pf.hit", 1'b0, 1'b0, 32'h0, word_at(32'h10));
        tick();
        expect_out("pf.copied", 1'b0, 1'b0, 32'h0, word_at(32'h10));
        set_pc(32'h1C);
        expect_out("pf.copied_last", 1'b0, 1'b0, 32'h0, word_at(32'h1C));
        tick();
        set_pc(32'h20);
        run_fill(32'h20, "fill20");
        tick();
        expect_out("pf2.beat0", 1'b0, 1'b1, 32'h30, word_at(32'h20));
        tick();
        set_pc(32'h200);
        expect_out("pf2.abort", 1'b1, 1'b1, 32'h34, NOP);
        for (int b = 0; b < 4; b++) begin
            tick();
            expect_out($sformatf("fill200.beat%0d", b), 1'b1, 1'b1, 32'h200 + 32'(4 * b), NOP);
        end
        tick();
        expect_out("fill200.done", 1'b0, 1'b0, 32'h0, word_at(32'h200));
`else
        for (int i = 0; i < 4; i++) begin
            set_pc(32'(4 * i));
            expect_out($sformatf("seq%0d", i), 1'b0, 1'b0, 32'h0, word_at(32'(4 * i)));
            tick();
        end

        // Acks with no request outstanding must leave the line untouched.
        stray_ack = 1'b1;
        set_pc(32'h8);
        expect_out("stray.during", 1'b0, 1'b0, 32'h0, word_at(32'h8));
        tick();
        tick();
        stray_ack = 1'b0;
        expect_out("stray.after", 1'b0, 1'b0, 32'h0, word_at(32'h8));

        delay_addr = 32'h44;
        delay_n    = 3;
        set_pc(32'h40);
        expect_out("dly.miss", 1'b1, 1'b0, 32'h0, NOP);
        tick();
        expect_out("dly.beat0", 1'b1, 1'b1, 32'h40, NOP);
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_out($sformatf("dly.hold%0d", k), 1'b1, 1'b1, 32'h44, NOP);
        end
        tick();
        expect_out("dly.beat2", 1'b1, 1'b1, 32'h48, NOP);
        tick();
        expect_out("dly.beat3", 1'b1, 1'b1, 32'h4C, NOP);
        tick();
        expect_out("dly.done", 1'b0, 1'b0, 32'h0, word_at(32'h40));
        delay_n = 0;
        set_pc(32'h44);
        expect_out("dly.word1", 1'b0, 1'b0, 32'h0, word_at(32'h44));
        tick();
        set_pc(32'h4C);
        expect_out("dly.word3", 1'b0, 1'b0, 32'h0, word_at(32'h4C));
        tick();

        set_pc(32'h100);
        run_fill(32'h100, "fill100");
        tick();
        set_pc(32'h0);
        run_fill(32'h0, "refill0");
        tick();

        // Old line 0x100 must not be reported after the tag changed; PC moves away mid-fill.
        set_pc(32'h10C);
        expect_out("stale.miss", 1'b1, 1'b0, 32'h0, NOP);
        tick();
        expect_out("mv.beat0", 1'b1, 1'b1, 32'h100, NOP);
        tick();
        set_pc(32'h300);
        expect_out("mv.beat1", 1'b1, 1'b1, 32'h104, NOP);
        tick();
        expect_out("mv.beat2", 1'b1, 1'b1, 32'h108, NOP);
        tick();
        expect_out("mv.beat3", 1'b1, 1'b1, 32'h10C, NOP);
        tick();
        set_pc(32'h10C);
        expect_out("mv.done", 1'b0, 1'b0, 32'h0, word_at(32'h10C));
        tick();
        set_pc(32'h300);
        run_fill(32'h300, "fill300");
        tick();

        set_pc(32'h0);
        expect_out("rstf.miss", 1'b1, 1'b0, 32'h0, NOP);
        tick();
        tick();
        tick();
        expect_out("rstf.beat2", 1'b1, 1'b1, 32'h8, NOP);
        w_rst_n = 1'b0;
        #1;
        expect_out("rstf.async", 1'b1, 1'b0, 32'h0, NOP);
        set_pc(32'h300);
        check_bit("rstf.valid_cleared", w_stall, 1'b1);
        tick();
        set_pc(32'h0);
        w_rst_n = 1'b1;
        #1;
        run_fill(32'h0, "rstf.refill");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
